// File: rtl/vec_irq_responder.sv
// ============================================================================
// Module   : vec_irq_responder
// Brief    : Device-side vectored-interrupt responder for one CPU priority level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vec_irq_responder #(
    parameter int             N       = 4,
    parameter logic [9*N-1:0] VECTORS = {9'o074, 9'o070, 9'o064, 9'o060},
    parameter logic [8:0]     PASSIVE = 9'o000
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic [N-1:0] dev_irq,
    output logic [N-1:0] dev_iack,
    output logic         irq_o,
    input  logic         istb_i,
    output logic [8:0]   ivec_o,
    output logic         iack_o
);

    localparam int SEL_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_VEC  = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic               r_passive;
    logic               w_passive_nxt;
    logic               r_irq;
    logic               w_irq_nxt;
    logic [8:0]         r_vec;
    logic [8:0]         w_vec_nxt;
    logic               r_iack;
    logic               w_iack_nxt;
    logic [N-1:0]       r_dev_iack;
    logic [N-1:0]       w_dev_iack_nxt;

    logic               w_any;
    logic [SEL_W-1:0]   w_pick;
    logic [N-1:0]       w_sel_onehot;
    logic [8:0]         w_vec_tab [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_vec_tab
        assign w_vec_tab[gi] = VECTORS[9*gi +: 9];
    end

    // Priority encoder: lowest index wins, so scan downward and let it overwrite.
    always_comb begin
        w_any  = |dev_irq;
        w_pick = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (dev_irq[i]) begin
                w_pick = SEL_W'(i);
            end
        end
    end

    always_comb begin
        w_sel_onehot = '0;
        for (int i = 0; i < N; i++) begin
            w_sel_onehot[i] = (r_sel == SEL_W'(i));
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_passive_nxt  = r_passive;
        w_irq_nxt      = 1'b0;
        w_vec_nxt      = r_vec;
        w_iack_nxt     = r_iack;
        w_dev_iack_nxt = '0;
        case (r_state)
            ST_IDLE: begin
                w_irq_nxt  = w_any & ~istb_i;
                w_vec_nxt  = '0;
                w_iack_nxt = 1'b0;
                // Arbitration is frozen here; later request changes cannot disturb the vector.
                if (istb_i) begin
                    w_sel_nxt     = w_pick;
                    w_passive_nxt = ~w_any;
                    w_vec_nxt     = w_any ? w_vec_tab[w_pick] : PASSIVE;
                    w_state_nxt   = ST_VEC;
                end
            end
            ST_VEC: begin
                if (istb_i) begin
                    w_iack_nxt     = 1'b1;
                    w_dev_iack_nxt = r_passive ? '0 : w_sel_onehot;
                    w_state_nxt    = ST_ACK;
                end else begin
                    w_vec_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACK: begin
                if (!istb_i) begin
                    w_iack_nxt  = 1'b0;
                    w_vec_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_vec_nxt   = '0;
                w_iack_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_passive  <= 1'b0;
            r_irq      <= 1'b0;
            r_vec      <= '0;
            r_iack     <= 1'b0;
            r_dev_iack <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_passive  <= w_passive_nxt;
            r_irq      <= w_irq_nxt;
            r_vec      <= w_vec_nxt;
            r_iack     <= w_iack_nxt;
            r_dev_iack <= w_dev_iack_nxt;
        end
    end

    assign irq_o    = r_irq;
    assign ivec_o   = r_vec;
    assign iack_o   = r_iack;
    assign dev_iack = r_dev_iack;

endmodule

`default_nettype wire

// File: tb/tb_vec_irq_responder.sv
// ============================================================================
// Module   : tb_vec_irq_responder
// Brief    : Directed and randomized bench for vec_irq_responder against a handshake model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vec_irq_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] dev_irq;
    logic [3:0] dev_iack;
    logic       irq_o;
    logic       istb;
    logic [8:0] ivec;
    logic       iack;

    int n_checks = 0;
    int n_errors = 0;

    vec_irq_responder dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .dev_irq  (dev_irq),
        .dev_iack (dev_iack),
        .irq_o    (irq_o),
        .istb_i   (istb),
        .ivec_o   (ivec),
        .iack_o   (iack)
    );

    always #5 clk = ~clk;

    // Reference: handshake phase 0 = waiting, 1 = vector presented, 2 = acknowledged.
    logic [8:0] vtab [4] = '{9'o060, 9'o064, 9'o070, 9'o074};
    int         phase = 0;
    int         winner = 0;
    bit         passive = 1'b0;
    logic       e_irq = 1'b0;
    logic [8:0] e_vec = '0;
    logic       e_iack = 1'b0;
    logic [3:0] e_dev = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        int lowest;
        lowest = -1;
        for (int i = 3; i >= 0; i--) if (dev_irq[i]) lowest = i;
        e_dev = '0;
        if (rst) begin
            phase = 0; winner = 0; passive = 1'b0;
            e_irq = 1'b0; e_vec = '0; e_iack = 1'b0;
        end else if (phase == 0) begin
            e_irq  = (dev_irq != 0) && !istb;
            e_vec  = '0;
            e_iack = 1'b0;
            if (istb) begin
                passive = (lowest < 0);
                winner  = passive ? 0 : lowest;
                e_vec   = passive ? 9'o000 : vtab[winner];
                phase   = 1;
            end
        end else if (phase == 1) begin
            e_irq = 1'b0;
            if (istb) begin
                e_iack = 1'b1;
                e_dev  = passive ? 4'b0000 : (4'b0001 << winner);
                phase  = 2;
            end else begin
                e_vec = '0;
                phase = 0;
            end
        end else begin
            e_irq = 1'b0;
            if (!istb) begin
                e_iack = 1'b0;
                e_vec  = '0;
                phase  = 0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("irq_o", irq_o, e_irq);
        chk("ivec_o", ivec, e_vec);
        chk("iack_o", iack, e_iack);
        chk("dev_iack", dev_iack, e_dev);
    endtask

    // Full handshake: strobe, expect vector, expect grant, winner drops, release strobe.
    task automatic handshake(input logic [8:0] xvec, input logic [3:0] xdev);
        istb = 1'b1;
        step();
        chk("hs_vec", ivec, xvec);
        step();
        chk("hs_iack", iack, 1'b1);
        chk("hs_dev_iack", dev_iack, xdev);
        dev_irq = dev_irq & ~xdev;
        step();
        istb = 1'b0;
        step();
        chk("hs_iack_fall", iack, 1'b0);
        chk("hs_vec_clear", ivec, 9'o000);
    endtask

    initial begin
        rst = 1'b1; dev_irq = '0; istb = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset in the middle of an acknowledged handshake.
        dev_irq = 4'b0001; istb = 1'b1;
        step(); step();
        chk("pre_rst_iack", iack, 1'b1);
        rst = 1'b1;
        step(); step();
        rst = 1'b0; istb = 1'b0; dev_irq = '0;
        chk("rst_irq", irq_o, 1'b0);
        chk("rst_iack", iack, 1'b0);
        chk("rst_vec", ivec, 9'o000);
        chk("rst_dev", dev_iack, 4'b0000);
        step();

        // Single request on source 2.
        dev_irq = 4'b0100;
        step();
        chk("single_irq", irq_o, 1'b1);
        handshake(9'o070, 4'b0100);

        // Priority: source 1 beats source 3; source 3 served next.
        dev_irq = 4'b1010;
        step();
        handshake(9'o064, 4'b0010);
        step();
        chk("prio_rearm", irq_o, 1'b1);
        handshake(9'o074, 4'b1000);

        // Passive strobe with nothing pending.
        handshake(9'o000, 4'b0000);

        // Abort after a single strobe cycle.
        dev_irq = 4'b0001;
        step();
        istb = 1'b1;
        step();
        istb = 1'b0;
        step();
        chk("abort_vec", ivec, 9'o000);
        chk("abort_iack", iack, 1'b0);
        chk("abort_dev", dev_iack, 4'b0000);
        step();
        chk("abort_rearm", irq_o, 1'b1);
        handshake(9'o060, 4'b0001);

        // Late request from source 0 after arbitration froze on source 1.
        dev_irq = 4'b0010;
        step();
        istb = 1'b1;
        step();
        dev_irq = 4'b0011;
        step();
        chk("late_vec", ivec, 9'o064);
        chk("late_dev", dev_iack, 4'b0010);
        dev_irq = 4'b0001;
        step();
        istb = 1'b0;
        step(); step();
        handshake(9'o060, 4'b0001);

        // Randomized traffic: level-holding devices, a CPU that strobes, aborts and releases.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic [3:0] acked;
            acked = e_dev;
            dev_irq = dev_irq & ~acked;
            if ($urandom_range(0, 5) == 0) dev_irq = dev_irq | ((4'b0001 << $urandom_range(0, 3)) & ~acked);
            if (!istb) begin
                if ((e_irq && $urandom_range(0, 2) != 0) || $urandom_range(0, 24) == 0) istb = 1'b1;
            end else if (e_iack) begin
                if ($urandom_range(0, 1) == 0) istb = 1'b0;
            end else if (phase == 1 && $urandom_range(0, 7) == 0) begin
                istb = 1'b0;
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
            chk("dev_iack_onehot", $onehot0(dev_iack), 1'b1);
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
